// File: rtl/rv32_pkg.sv
// Shared constants and the writeback-arbiter state encoding for the RV32 core.
package rv32_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int STREAK_MAX = 3;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } rf_wb_state_t;
endpackage

// File: rtl/rf_wb_arbiter_if.sv
// ALU and LSU writeback request channels into the regfile write arbiter.
// Handshake: a request transfers on a rising edge where valid and ready are both
// high; the requester keeps valid, rd and wd stable until that edge.
interface rf_wb_arbiter_if #(
  parameter int XLEN = rv32_pkg::XLEN
);
  logic                            alu_valid;
  logic [rv32_pkg::REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]                 alu_wd;
  logic                            alu_ready;
  logic                            lsu_valid;
  logic [rv32_pkg::REG_ADDR_W-1:0] lsu_rd;
  logic [XLEN-1:0]                 lsu_wd;
  logic                            lsu_ready;

  modport master (
    output alu_valid, alu_rd, alu_wd, input alu_ready,
    output lsu_valid, lsu_rd, lsu_wd, input lsu_ready
  );

  modport slave (
    input alu_valid, alu_rd, alu_wd, output alu_ready,
    input lsu_valid, lsu_rd, lsu_wd, output lsu_ready
  );
endinterface

// File: rtl/wb_prio_arb.sv
// LSU-first grant logic with a streak limit so a waiting ALU request is never
// starved for more than STREAK_MAX consecutive LSU grants.
module wb_prio_arb #(
  parameter int STREAK_MAX = rv32_pkg::STREAK_MAX
) (
  input  logic clk,
  input  logic rst_n,
  input  logic arb_en,
  input  logic alu_valid,
  input  logic lsu_valid,
  output logic grant_alu,
  output logic grant_lsu
);
  localparam int SW = $clog2(STREAK_MAX + 1);
  localparam logic [SW-1:0] STREAK_LIM = SW'(STREAK_MAX);

  logic [SW-1:0] streak;

  always_comb begin
    grant_lsu = arb_en && lsu_valid && (streak < STREAK_LIM);
    grant_alu = arb_en && alu_valid && !grant_lsu;
  end

  // Streak only counts LSU wins that actually made the ALU wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak <= '0;
    end else if (grant_alu || !alu_valid) begin
      streak <= '0;
    end else if (grant_lsu) begin
      streak <= streak + SW'(1);
    end
  end
endmodule

// File: rtl/rf_wb_arbiter.sv
// Regfile write-port owner: zeroes x1..x31 after reset or on clear, then
// arbitrates ALU/LSU writebacks into a registered single write port.
module rf_wb_arbiter #(
  parameter int XLEN       = rv32_pkg::XLEN,
  parameter int STREAK_MAX = rv32_pkg::STREAK_MAX
) (
  input  logic                            clk,
  input  logic                            rst_n,
  rf_wb_arbiter_if.slave                  wb,
  input  logic                            clr_req,
  output logic                            rf_we,
  output logic [rv32_pkg::REG_ADDR_W-1:0] rf_rd,
  output logic [XLEN-1:0]                 rf_wd,
  output logic                            init_done,
  output rv32_pkg::rf_wb_state_t          dbg_state
);
  import rv32_pkg::REG_ADDR_W;
  import rv32_pkg::NUM_REGS;
  import rv32_pkg::rf_wb_state_t;
  import rv32_pkg::INIT;
  import rv32_pkg::RUN;

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

  rf_wb_state_t            state;
  logic [REG_ADDR_W-1:0]   idx;
  logic                    arb_en;
  logic                    grant_alu;
  logic                    grant_lsu;
  logic                    take;
  logic [REG_ADDR_W-1:0]   sel_rd;
  logic [XLEN-1:0]         sel_wd;

  assign arb_en = (state == RUN) && !clr_req;

  wb_prio_arb #(
    .STREAK_MAX(STREAK_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_en    (arb_en),
    .alu_valid (wb.alu_valid),
    .lsu_valid (wb.lsu_valid),
    .grant_alu (grant_alu),
    .grant_lsu (grant_lsu)
  );

  assign wb.alu_ready = grant_alu;
  assign wb.lsu_ready = grant_lsu;

  // A grant is only ever issued to a valid requester, so grant == acceptance.
  always_comb begin
    take   = grant_alu || grant_lsu;
    sel_rd = grant_lsu ? wb.lsu_rd : wb.alu_rd;
    sel_wd = grant_lsu ? wb.lsu_wd : wb.alu_wd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT;
      idx   <= REG_ADDR_W'(1);
      rf_we <= 1'b0;
      rf_rd <= '0;
      rf_wd <= '0;
    end else if (state == INIT) begin
      rf_we <= 1'b1;
      rf_rd <= idx;
      rf_wd <= '0;
      idx   <= idx + REG_ADDR_W'(1);
      if (idx == LAST_IDX) begin
        state <= RUN;
      end
    end else if (clr_req) begin
      state <= INIT;
      idx   <= REG_ADDR_W'(1);
      rf_we <= 1'b0;
    end else if (take && (sel_rd != '0)) begin
      rf_we <= 1'b1;
      rf_rd <= sel_rd;
      rf_wd <= sel_wd;
    end else begin
      // x0 writes are consumed silently; rd/wd keep their last value.
      rf_we <= 1'b0;
    end
  end

  assign init_done = (state == RUN);
  assign dbg_state = state;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: directed scenarios plus a randomized
// run against a request-level reference model with a write scoreboard.
module tb_rf_wb_arbiter;
  import rv32_pkg::*;

  localparam int W  = 32;
  localparam int SM = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr_req = 1'b0;
  logic         rf_we;
  logic [4:0]   rf_rd;
  logic [W-1:0] rf_wd;
  logic         init_done;
  rf_wb_state_t dbg_state;

  int checks = 0;
  int errors = 0;

  logic [W-1:0]   rf_mem [32];
  logic [5+W-1:0] exp_q[$];

  always #5 clk = ~clk;

  rf_wb_arbiter_if #(.XLEN(W)) wb();

  rf_wb_arbiter #(.XLEN(W), .STREAK_MAX(SM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb.slave),
    .clr_req   (clr_req),
    .rf_we     (rf_we),
    .rf_rd     (rf_rd),
    .rf_wd     (rf_wd),
    .init_done (init_done),
    .dbg_state (dbg_state)
  );

  // Raw regfile storage: records every commit, including any stray x0 write.
  always @(posedge clk) begin
    if (rf_we) rf_mem[rf_rd] = rf_wd;
  end

  task automatic drive_idle();
    wb.alu_valid = 1'b0; wb.alu_rd = '0; wb.alu_wd = '0;
    wb.lsu_valid = 1'b0; wb.lsu_rd = '0; wb.lsu_wd = '0;
    clr_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_wd = $urandom;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_wd = $urandom;
    repeat (3) @(negedge clk);
    checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", rf_rd); end
    checks++; if (rf_wd !== '0) begin errors++; $display("FAIL reset_wd: got %h expected 0", rf_wd); end
    checks++; if (init_done !== 1'b0) begin errors++; $display("FAIL reset_init_done: got %b expected 0", init_done); end
    checks++; if ({wb.alu_ready, wb.lsu_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {wb.alu_ready, wb.lsu_ready}); end
    checks++; if (dbg_state !== INIT) begin errors++; $display("FAIL reset_state: got %0d expected INIT", dbg_state); end
    drive_idle();
  endtask

  task automatic test_init();
    int nz;
    rst_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(i) || rf_wd !== '0) begin errors++;
        $display("FAIL init_write[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=0", i, rf_we, rf_rd, rf_wd, i); end
      checks++; if (init_done !== (i == 31)) begin errors++; $display("FAIL init_done[%0d]: got %b expected %b", i, init_done, i == 31); end
      if (i < 31) begin
        checks++; if ({wb.alu_ready, wb.lsu_ready} !== 2'b00) begin errors++; $display("FAIL init_ready[%0d]: got %b expected 00", i, {wb.alu_ready, wb.lsu_ready}); end
      end
      // Requests and a clear pulse during init must be ignored.
      wb.lsu_valid = (i >= 5 && i < 20); wb.lsu_rd = 5'd9; wb.lsu_wd = 32'hCAFE0009;
      clr_req = (i == 10);
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b0 || init_done !== 1'b1) begin errors++; $display("FAIL init_end: got we=%b done=%b expected we=0 done=1", rf_we, init_done); end
    nz = 0;
    for (int r = 1; r < 32; r++) if (rf_mem[r] !== '0) nz++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL init_zeroed: got %0d nonzero regs expected 0", nz); end
  endtask

  task automatic test_single_alu();
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd5; wb.alu_wd = 32'h11111111;
    #1;
    checks++; if ({wb.alu_ready, wb.lsu_ready} !== 2'b10) begin errors++; $display("FAIL alu_ready: got %b expected 10", {wb.alu_ready, wb.lsu_ready}); end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd5 || rf_wd !== 32'h11111111) begin errors++;
      $display("FAIL alu_write: got we=%b rd=%0d wd=%h expected we=1 rd=5 wd=11111111", rf_we, rf_rd, rf_wd); end
    wb.alu_valid = 1'b0;
    @(negedge clk);
    checks++; if (rf_mem[5] !== 32'h11111111 || rf_we !== 1'b0) begin errors++; $display("FAIL alu_commit: got x5=%h we=%b expected x5=11111111 we=0", rf_mem[5], rf_we); end
  endtask

  task automatic test_starvation();
    logic [4:0]   a_rd = 5'd10, l_rd = 5'd20, e_rd;
    logic [W-1:0] a_wd = $urandom, l_wd = $urandom, e_wd;
    bit exp_lsu;
    for (int c = 0; c < 12; c++) begin
      wb.alu_valid = 1'b1; wb.alu_rd = a_rd; wb.alu_wd = a_wd;
      wb.lsu_valid = 1'b1; wb.lsu_rd = l_rd; wb.lsu_wd = l_wd;
      #1;
      exp_lsu = (c % 4) != 3;
      checks++; if ({wb.alu_ready, wb.lsu_ready} !== {!exp_lsu, exp_lsu}) begin errors++;
        $display("FAIL starve_grant[%0d]: got alu/lsu=%b expected %b", c, {wb.alu_ready, wb.lsu_ready}, {!exp_lsu, exp_lsu}); end
      e_rd = exp_lsu ? l_rd : a_rd;
      e_wd = exp_lsu ? l_wd : a_wd;
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_rd !== e_rd || rf_wd !== e_wd) begin errors++;
        $display("FAIL starve_write[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=%h", c, rf_we, rf_rd, rf_wd, e_rd, e_wd); end
      if (exp_lsu) begin l_rd++; l_wd = $urandom; end
      else begin a_rd++; a_wd = $urandom; end
    end
    drive_idle();
    @(negedge clk);
  endtask

  task automatic test_x0();
    for (int c = 0; c < 4; c++) begin
      wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0; wb.lsu_wd = 32'hDEADBEEF;
      wb.alu_valid = 1'b1; wb.alu_rd = 5'd3; wb.alu_wd = 32'h33333333;
      #1;
      checks++; if ({wb.alu_ready, wb.lsu_ready} !== ((c == 3) ? 2'b10 : 2'b01)) begin errors++;
        $display("FAIL x0_grant[%0d]: got alu/lsu=%b expected %b", c, {wb.alu_ready, wb.lsu_ready}, (c == 3) ? 2'b10 : 2'b01); end
      @(negedge clk);
      checks++; if (rf_we !== (c == 3)) begin errors++; $display("FAIL x0_we[%0d]: got %b expected %b", c, rf_we, c == 3); end
      if (c == 3) wb.alu_valid = 1'b0;
    end
    drive_idle();
    @(negedge clk);
    checks++; if (rf_mem[0] !== '0) begin errors++; $display("FAIL x0_value: got %h expected 0", rf_mem[0]); end
    checks++; if (rf_mem[3] !== 32'h33333333) begin errors++; $display("FAIL x0_alu_after: got %h expected 33333333", rf_mem[3]); end
  endtask

  // Reference: LSU wins unless it has already won SM times in a row while the
  // ALU was waiting; rd=0 grants produce no write.
  task automatic test_random();
    bit a_pend = 0, l_pend = 0, g_alu, g_lsu;
    logic [4:0]   a_rd = '0, l_rd = '0;
    logic [W-1:0] a_wd = '0, l_wd = '0;
    logic [5+W-1:0] e;
    int wins = 0;
    for (int it = 0; it < 320; it++) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++; if (rf_we !== 1'b1 || {rf_rd, rf_wd} !== e) begin errors++;
          $display("FAIL rand_write[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=%h", it, rf_we, rf_rd, rf_wd, e[W+4:W], e[W-1:0]); end
      end else begin
        checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rand_idle[%0d]: got we=%b expected 0", it, rf_we); end
      end
      if (it < 290) begin
        if (!a_pend && $urandom_range(0, 99) < 60) begin a_pend = 1; a_rd = 5'($urandom_range(0, 31)); a_wd = $urandom; end
        if (!l_pend && $urandom_range(0, 99) < 60) begin l_pend = 1; l_rd = 5'($urandom_range(0, 31)); l_wd = $urandom; end
      end
      wb.alu_valid = a_pend; wb.alu_rd = a_rd; wb.alu_wd = a_wd;
      wb.lsu_valid = l_pend; wb.lsu_rd = l_rd; wb.lsu_wd = l_wd;
      #1;
      g_lsu = l_pend && (wins < SM);
      g_alu = a_pend && !g_lsu;
      checks++; if ({wb.alu_ready, wb.lsu_ready} !== {g_alu, g_lsu}) begin errors++;
        $display("FAIL rand_grant[%0d]: got alu/lsu=%b expected %b", it, {wb.alu_ready, wb.lsu_ready}, {g_alu, g_lsu}); end
      if (g_lsu && a_pend) wins++;
      else if (g_alu || !a_pend) wins = 0;
      if (g_lsu) begin l_pend = 0; if (l_rd != 0) exp_q.push_back({l_rd, l_wd}); end
      if (g_alu) begin a_pend = 0; if (a_rd != 0) exp_q.push_back({a_rd, a_wd}); end
      @(negedge clk);
    end
    checks++; if (exp_q.size() != 0 || a_pend || l_pend) begin errors++;
      $display("FAIL rand_drain: got %0d queued, pend=%b%b expected none", exp_q.size(), a_pend, l_pend); end
    drive_idle();
  endtask

  task automatic test_clear();
    int nz;
    wb.alu_valid = 1'b1; wb.alu_rd = 5'd7; wb.alu_wd = 32'h77777777;
    clr_req = 1'b1;
    #1;
    checks++; if ({wb.alu_ready, wb.lsu_ready} !== 2'b00) begin errors++; $display("FAIL clr_ready: got %b expected 00", {wb.alu_ready, wb.lsu_ready}); end
    @(negedge clk);
    clr_req = 1'b0;
    checks++; if (rf_we !== 1'b0 || init_done !== 1'b0 || dbg_state !== INIT) begin errors++;
      $display("FAIL clr_enter: got we=%b done=%b state=%0d expected we=0 done=0 state=INIT", rf_we, init_done, dbg_state); end
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      checks++; if (rf_we !== 1'b1 || rf_rd !== 5'(i) || rf_wd !== '0) begin errors++;
        $display("FAIL clr_init[%0d]: got we=%b rd=%0d wd=%h expected we=1 rd=%0d wd=0", i, rf_we, rf_rd, rf_wd, i); end
      checks++; if (wb.alu_ready !== (i == 31)) begin errors++; $display("FAIL clr_hold_ready[%0d]: got %b expected %b", i, wb.alu_ready, i == 31); end
    end
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd7 || rf_wd !== 32'h77777777) begin errors++;
      $display("FAIL clr_held_write: got we=%b rd=%0d wd=%h expected we=1 rd=7 wd=77777777", rf_we, rf_rd, rf_wd); end
    nz = 0;
    for (int r = 1; r < 32; r++) if (rf_mem[r] !== '0) nz++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL clr_zeroed: got %0d nonzero regs expected 0", nz); end
    drive_idle();
    @(negedge clk);
    checks++; if (rf_mem[7] !== 32'h77777777) begin errors++; $display("FAIL clr_x7: got %h expected 77777777", rf_mem[7]); end
  endtask

  task automatic test_mid_init_reset();
    int budget = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    do begin
      @(negedge clk);
      budget++;
    end while (rf_rd !== 5'd9 && budget < 40);
    checks++; if (rf_rd !== 5'd9) begin errors++; $display("FAIL midrst_reach: got rd=%0d expected 9 within 40 cycles", rf_rd); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rf_we !== 1'b0 || rf_rd !== 5'd0 || rf_wd !== '0 || init_done !== 1'b0 || dbg_state !== INIT) begin errors++;
      $display("FAIL midrst_outputs: got we=%b rd=%0d wd=%h done=%b state=%0d expected all 0", rf_we, rf_rd, rf_wd, init_done, dbg_state); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (rf_we !== 1'b1 || rf_rd !== 5'd1) begin errors++; $display("FAIL midrst_restart: got we=%b rd=%0d expected we=1 rd=1", rf_we, rf_rd); end
    repeat (30) @(negedge clk);
    checks++; if (init_done !== 1'b1 || rf_rd !== 5'd31) begin errors++; $display("FAIL midrst_done: got done=%b rd=%0d expected done=1 rd=31", init_done, rf_rd); end
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_mem[r] = (r == 0) ? '0 : (32'hA5A50000 + 32'(r));
    drive_idle();
    test_reset();
    test_init();
    test_single_alu();
    test_starvation();
    test_x0();
    test_random();
    test_clear();
    test_mid_init_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, the data width.
REQ-002 The block SHALL have parameter STREAK_MAX, default 3, the maximum number of consecutive LSU grants while the ALU waits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have ports alu_valid (input, 1), alu_rd (input, 5), alu_wd (input, XLEN) and alu_ready (output, 1) forming the ALU writeback request.
REQ-006 The block SHALL have ports lsu_valid (input, 1), lsu_rd (input, 5), lsu_wd (input, XLEN) and lsu_ready (output, 1) forming the load writeback request.
REQ-007 The block SHALL have port clr_req, input, 1 bit: a one-cycle request to re-zero the register file.
REQ-008 The block SHALL have ports rf_we (output, 1), rf_rd (output, 5) and rf_wd (output, XLEN), which drive the regfile write port and are all registered.
REQ-009 The block SHALL have port init_done, output, 1 bit: high while in the RUN state.

Function
REQ-010 The FSM SHALL have exactly two states, INIT and RUN, with a 5-bit index counter idx.
REQ-011 In INIT, each rising edge SHALL load rf_we=1, rf_rd=idx and rf_wd=0, then increment idx.
REQ-012 At the edge where idx=31 is loaded, the FSM SHALL move to RUN, so x1..x31 are written in 31 consecutive cycles.
REQ-013 In INIT, alu_ready and lsu_ready SHALL both be 0, and clr_req SHALL be ignored.
REQ-014 In RUN, a request SHALL be accepted in a cycle where valid and ready are both high at the rising edge.
REQ-015 Requesters SHALL hold valid, rd and wd stable until accepted.
REQ-016 Each ready output SHALL be combinational: the state is RUN, clr_req is 0, and that requester holds the grant.
REQ-017 Grant SHALL go to the LSU when lsu_valid=1 and streak<STREAK_MAX.
REQ-018 Otherwise, grant SHALL go to the ALU when alu_valid=1.
REQ-019 When the LSU is granted and alu_valid=1, streak SHALL increment.
REQ-020 When the ALU is granted, or alu_valid=0, streak SHALL clear to 0.
REQ-021 Write latency SHALL be one cycle: an acceptance at edge N gives rf_we=1, rf_rd=rd and rf_wd=wd after edge N, and the regfile commits at edge N+1.
REQ-022 A cycle with no acceptance SHALL load rf_we=0, leaving rf_rd and rf_wd unchanged.
REQ-023 An accepted request with rd=0 SHALL be consumed and produce rf_we=0; it SHALL still count as a grant for streak purposes.
REQ-024 When clr_req=1 in RUN, no request SHALL be accepted that cycle; at the next edge the FSM SHALL enter INIT with idx=1 and rf_we=0.
REQ-025 When both requesters are valid for the same rd, only the granted request SHALL be written that cycle; the other stays pending.

Reset
REQ-026 While rst_n=0, outputs SHALL be: rf_we=0, rf_rd=0, rf_wd=0, init_done=0, alu_ready=0, lsu_ready=0.
REQ-027 While rst_n=0, internal state SHALL be: state=INIT, idx=1, streak=0.
REQ-028 Reset asserted mid-INIT or mid-RUN SHALL abort immediately, discarding any in-flight write.

Structure
REQ-029 Package rv32_pkg SHALL hold XLEN, REG_ADDR_W=5, NUM_REGS=32, the rf_wb_state_t encoding (INIT=0, RUN=1) and the STREAK_MAX default.
REQ-030 One sub-module, wb_prio_arb, SHALL hold the grant logic and the streak counter; the FSM and output registers stay in the top.

Verification
REQ-031 The bench SHALL cover init: release rst_n -> rf_we=1 for 31 cycles with rf_rd=1..31 and rf_wd=0, then init_done=1 and rf_we=0.
REQ-032 The bench SHALL cover a single ALU write: alu_valid, rd=5, wd=0x11111111 -> alu_ready same cycle, then rf_we=1, rf_rd=5, rf_wd=0x11111111 one cycle later, and regfile x5 reads 0x11111111.
REQ-033 The bench SHALL cover starvation: both requesters held valid continuously -> grant sequence LSU,LSU,LSU,ALU repeating.
REQ-034 The bench SHALL cover x0: lsu_valid with rd=0 and wd=0xDEADBEEF -> lsu_ready=1, rf_we stays 0, and x0 reads 0.
REQ-035 The bench SHALL cover clear: clr_req with alu_valid held -> alu_ready=0, re-init of x1..x31 to 0, then the held ALU request is accepted after init_done.
REQ-036 The bench SHALL cover mid-init reset: rst_n=0 at idx=10 -> outputs 0 immediately, and init restarts at rf_rd=1 after release.
